formula_checker_seq: RTL
========================

Name: formula_checker_seq

Overview:
Parametrised, time-multiplexed successor to the flat per-clause formula checker. It holds a formula of NUM_CLAUSES clauses in an internal clause memory, with a per-clause enable and integer-literal enable. On a start handshake it evaluates LANES clauses per cycle against a snapshot of the integer/boolean assignment. It reports overall satisfaction, a per-clause result vector, the unsatisfied count and the first unsatisfied index. Optional early-exit mode. Sits between the MCMC move proposer and the accept/reject logic.

Parameters:
INT_COEF_W, 4, signed integer coefficient/bias width
INT_VAR_W, 4, signed integer variable value width
NUM_INT_VARS, 2, integer variables per clause
NUM_BOOL_VARS, 2, boolean variables per clause
NUM_CLAUSES, 4, clauses stored (any value >=1, not only powers of 2)
LANES, 1, clauses evaluated per cycle (1..NUM_CLAUSES)

Ports:
in_clk  in  1  clock
in_reset  in  1  asynchronous, active-low reset
in_cfg_we  in  1  write clause memory entry
in_cfg_index  in  clog2(NUM_CLAUSES)  clause written
in_cfg_int_coefs  in  (NUM_INT_VARS+1)*INT_COEF_W  coefs, bias in MS slice
in_cfg_bool_coefs  in  2*NUM_BOOL_VARS  boolean literal codes
in_cfg_int_en  in  1  integer literal present in clause
in_cfg_clause_en  in  1  clause participates in formula
in_start  in  1  start evaluation (accepted only in IDLE)
in_early_exit  in  1  mode, sampled with in_start
in_int_assign  in  NUM_INT_VARS*INT_VAR_W  signed integer assignment
in_bool_assign  in  NUM_BOOL_VARS  boolean assignment
out_busy  out  1  high in EVAL
out_done  out  1  one-cycle pulse, results valid
out_satisfied  out  1  all enabled, evaluated clauses satisfied
out_clause_sat  out  NUM_CLAUSES  per-clause result
out_unsat_count  out  clog2(NUM_CLAUSES+1)  unsatisfied clauses found
out_first_unsat_idx  out  clog2(NUM_CLAUSES)  lowest unsatisfied index
out_first_unsat_valid  out  1  at least one unsatisfied

Behaviour:
- Reset (async assert, sync deassert at use): FSM=IDLE. All outputs 0. Clause memory cleared, so all clauses are disabled.
- Integer literal: acc = sum(coef_i*x_i) + bias, signed. ACC_W = INT_COEF_W+INT_VAR_W+clog2(NUM_INT_VARS+1)+1. No overflow is possible. True iff int_en and acc <= 0.
- Boolean code per variable: 00 absent, 01 true when var=1, 10 true when var=0, 11 absent (reserved).
- Clause sat = int literal OR any boolean literal. A clause with no active literals is unsatisfied. A disabled clause is forced sat=1.
- FSM states: IDLE -> EVAL on in_start; EVAL -> DONE after the last batch; DONE -> IDLE after one cycle.
- On in_start, the assignment and in_early_exit are latched. Evaluation always uses the snapshot.
- EVAL covers ceil(NUM_CLAUSES/LANES) batches, one per cycle. In the final batch, lanes beyond NUM_CLAUSES are masked and contribute nothing.
- out_done pulses in DONE; result outputs are updated in the same cycle and held until the next in_start. Latency from start to done = batches+1 cycles.
- Early exit: if the latched mode is 1, the FSM goes to DONE after the first batch containing an unsat clause. Unevaluated clauses report out_clause_sat=0 but are excluded from out_satisfied and out_unsat_count.
- If all clauses are disabled, out_satisfied=1 and out_unsat_count=0.
- in_start while busy/DONE is ignored. in_cfg_we while not IDLE is dropped. Config write and start in the same IDLE cycle: the write lands first and the evaluation sees it.
- Reset mid-EVAL: immediate IDLE, no done pulse, memory cleared.

Decomposition:
- Package formula_checker_pkg holds: boolean literal code constants, the ACC_W function, the FSM state enum, and a clog2 helper.
- Sub-module clause_eval: a combinational single-clause evaluator, instantiated LANES times.

Test Plan:
1. Reset low mid-run -> next edge: busy=0, done=0, outputs 0. A subsequent start with no config -> satisfied=1, count=0, done after 5 cycles (NUM_CLAUSES=4, LANES=1).
2. Clause0: coefs x0=1, x1=1, bias=-5, int_en, enabled; x0=2, x1=2 -> acc=-1 -> satisfied=1, clause_sat=4'b1111. With x0=3, x1=3 -> acc=1 -> satisfied=0, count=1, first_idx=0.
3. Clause0 additionally bool code 01 on b0: b0=1 with x=3,3 -> satisfied. Code 10 with b0=1 -> unsatisfied.
4. Clauses 1 and 3 unsat, early_exit=0 -> count=2, first_idx=1, done at cycle 5. With early_exit=1 -> done at cycle 3, count=1, clause_sat[3:2]=00.
5. x0=-8, coef=-8, bias=-8, other coef 0 -> acc=56 -> unsat, no overflow. LANES=3, NUM_CLAUSES=4 -> done at cycle 3, masked lanes ignored.
6. Start pulse while busy and cfg write while busy -> both ignored; results and memory unchanged.

Source files
------------

// File: rtl/formula_checker_pkg.sv
// Shared constants, FSM encoding and width helpers for the sequential formula checker.
// Pure declarations: no timing and no handshake of its own.
package formula_checker_pkg;

  localparam logic [1:0] BOOL_ABSENT = 2'b00;
  localparam logic [1:0] BOOL_POS    = 2'b01;
  localparam logic [1:0] BOOL_NEG    = 2'b10;
  localparam logic [1:0] BOOL_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits for single-entry memories.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int acc_w(input int coef_w, input int var_w, input int num_vars);
    return coef_w + var_w + clog2(num_vars + 1) + 1;
  endfunction

endpackage

// File: rtl/formula_checker_seq_clause_eval.sv
// Single-clause evaluator: purely combinational, zero latency, no backpressure.
// Integer literal holds when enabled and the affine sum is <= 0; boolean literals are OR-ed in.
module clause_eval
  import formula_checker_pkg::*;
#(
  parameter int INT_COEF_W    = 4,
  parameter int INT_VAR_W     = 4,
  parameter int NUM_INT_VARS  = 2,
  parameter int NUM_BOOL_VARS = 2
) (
  input  logic [(NUM_INT_VARS+1)*INT_COEF_W-1:0] int_coefs,
  input  logic [2*NUM_BOOL_VARS-1:0]             bool_coefs,
  input  logic                                   int_en,
  input  logic                                   clause_en,
  input  logic [NUM_INT_VARS*INT_VAR_W-1:0]      int_assign,
  input  logic [NUM_BOOL_VARS-1:0]               bool_assign,
  output logic                                   sat
);

  localparam int ACC_W = acc_w(INT_COEF_W, INT_VAR_W, NUM_INT_VARS);

  logic signed [ACC_W-1:0] acc;
  logic                    bool_hit;

  always_comb begin
    acc = ACC_W'($signed(int_coefs[NUM_INT_VARS*INT_COEF_W +: INT_COEF_W]));
    for (int i = 0; i < NUM_INT_VARS; i++) begin
      acc = acc + ACC_W'($signed(int_coefs[i*INT_COEF_W +: INT_COEF_W]))
                * ACC_W'($signed(int_assign[i*INT_VAR_W +: INT_VAR_W]));
    end
  end

  always_comb begin
    bool_hit = 1'b0;
    for (int j = 0; j < NUM_BOOL_VARS; j++) begin
      case (bool_coefs[2*j +: 2])
        BOOL_POS:              if (bool_assign[j])  bool_hit = 1'b1;
        BOOL_NEG:              if (!bool_assign[j]) bool_hit = 1'b1;
        BOOL_ABSENT, BOOL_RSVD: bool_hit = bool_hit;
      endcase
    end
  end

  assign sat = !clause_en || (int_en && (acc <= 0)) || bool_hit;

endmodule

// File: rtl/formula_checker_seq.sv
// Time-multiplexed formula checker: LANES clauses per cycle, done pulses ceil(N/LANES)+1 cycles after start.
// No backpressure: start is only taken in IDLE, config writes outside IDLE are dropped.
module formula_checker_seq
  import formula_checker_pkg::*;
#(
  parameter int INT_COEF_W    = 4,
  parameter int INT_VAR_W     = 4,
  parameter int NUM_INT_VARS  = 2,
  parameter int NUM_BOOL_VARS = 2,
  parameter int NUM_CLAUSES   = 4,
  parameter int LANES         = 1
) (
  input  logic                                   in_clk,
  input  logic                                   in_reset,
  input  logic                                   in_cfg_we,
  input  logic [idx_w(NUM_CLAUSES)-1:0]          in_cfg_index,
  input  logic [(NUM_INT_VARS+1)*INT_COEF_W-1:0] in_cfg_int_coefs,
  input  logic [2*NUM_BOOL_VARS-1:0]             in_cfg_bool_coefs,
  input  logic                                   in_cfg_int_en,
  input  logic                                   in_cfg_clause_en,
  input  logic                                   in_start,
  input  logic                                   in_early_exit,
  input  logic [NUM_INT_VARS*INT_VAR_W-1:0]      in_int_assign,
  input  logic [NUM_BOOL_VARS-1:0]               in_bool_assign,
  output logic                                   out_busy,
  output logic                                   out_done,
  output logic                                   out_satisfied,
  output logic [NUM_CLAUSES-1:0]                 out_clause_sat,
  output logic [clog2(NUM_CLAUSES+1)-1:0]        out_unsat_count,
  output logic [idx_w(NUM_CLAUSES)-1:0]          out_first_unsat_idx,
  output logic                                   out_first_unsat_valid
);

  localparam int CIDX_W = idx_w(NUM_CLAUSES);
  localparam int CNT_W  = clog2(NUM_CLAUSES + 1);
  localparam int NB     = (NUM_CLAUSES + LANES - 1) / LANES;
  localparam int BW     = idx_w(NB);
  localparam int COEF_W = (NUM_INT_VARS + 1) * INT_COEF_W;

  state_t state, state_nxt;

  logic [COEF_W-1:0]          mem_coefs [NUM_CLAUSES];
  logic [2*NUM_BOOL_VARS-1:0] mem_bools [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0]     mem_int_en, mem_clause_en;

  logic [NUM_INT_VARS*INT_VAR_W-1:0] snap_int;
  logic [NUM_BOOL_VARS-1:0]          snap_bool;
  logic                              snap_early;
  logic [BW-1:0]                     batch;

  logic [NUM_CLAUSES-1:0] acc_cs, cs_nxt;
  logic [CNT_W-1:0]       acc_cnt, cnt_nxt;
  logic [CIDX_W-1:0]      acc_first, first_nxt;
  logic                   acc_fv, fv_nxt, batch_unsat;

  logic [LANES-1:0]  lane_vld, lane_sat;
  logic [CIDX_W-1:0] lane_idx [LANES];

  wire accept   = (state == ST_IDLE) && in_start;
  wire last_bat = (batch == BW'(NB - 1));

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_start) state_nxt = ST_EVAL;
      ST_EVAL: if (last_bat || (snap_early && batch_unsat)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_busy = (state == ST_EVAL);
    out_done = (state == ST_DONE);
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      for (int k = 0; k < NUM_CLAUSES; k++) begin
        mem_coefs[k] <= '0;
        mem_bools[k] <= '0;
      end
      mem_int_en    <= '0;
      mem_clause_en <= '0;
    end else if (state == ST_IDLE && in_cfg_we && (32'(in_cfg_index) < 32'(NUM_CLAUSES))) begin
      mem_coefs[in_cfg_index]     <= in_cfg_int_coefs;
      mem_bools[in_cfg_index]     <= in_cfg_bool_coefs;
      mem_int_en[in_cfg_index]    <= in_cfg_int_en;
      mem_clause_en[in_cfg_index] <= in_cfg_clause_en;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] pos;
    assign pos         = 32'(batch) * 32'(LANES) + 32'(l);
    assign lane_vld[l] = (pos < 32'(NUM_CLAUSES));
    assign lane_idx[l] = lane_vld[l] ? pos[CIDX_W-1:0] : '0;

    clause_eval #(
      .INT_COEF_W   (INT_COEF_W),
      .INT_VAR_W    (INT_VAR_W),
      .NUM_INT_VARS (NUM_INT_VARS),
      .NUM_BOOL_VARS(NUM_BOOL_VARS)
    ) u_eval (
      .int_coefs  (mem_coefs[lane_idx[l]]),
      .bool_coefs (mem_bools[lane_idx[l]]),
      .int_en     (mem_int_en[lane_idx[l]]),
      .clause_en  (mem_clause_en[lane_idx[l]]),
      .int_assign (snap_int),
      .bool_assign(snap_bool),
      .sat        (lane_sat[l])
    );
  end

  // Lanes are scanned low to high so the first unsat index stays the lowest one.
  always_comb begin
    cs_nxt      = acc_cs;
    cnt_nxt     = acc_cnt;
    first_nxt   = acc_first;
    fv_nxt      = acc_fv;
    batch_unsat = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_vld[l]) begin
        cs_nxt[lane_idx[l]] = lane_sat[l];
        if (!lane_sat[l]) begin
          batch_unsat = 1'b1;
          cnt_nxt     = cnt_nxt + CNT_W'(1);
          if (!fv_nxt) first_nxt = lane_idx[l];
          fv_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      snap_int              <= '0;
      snap_bool             <= '0;
      snap_early            <= 1'b0;
      batch                 <= '0;
      acc_cs                <= '0;
      acc_cnt               <= '0;
      acc_first             <= '0;
      acc_fv                <= 1'b0;
      out_satisfied         <= 1'b0;
      out_clause_sat        <= '0;
      out_unsat_count       <= '0;
      out_first_unsat_idx   <= '0;
      out_first_unsat_valid <= 1'b0;
    end else if (accept) begin
      snap_int   <= in_int_assign;
      snap_bool  <= in_bool_assign;
      snap_early <= in_early_exit;
      batch      <= '0;
      acc_cs     <= '0;
      acc_cnt    <= '0;
      acc_first  <= '0;
      acc_fv     <= 1'b0;
    end else if (state == ST_EVAL) begin
      batch     <= batch + BW'(1);
      acc_cs    <= cs_nxt;
      acc_cnt   <= cnt_nxt;
      acc_first <= first_nxt;
      acc_fv    <= fv_nxt;
      if (state_nxt == ST_DONE) begin
        out_satisfied         <= (cnt_nxt == '0);
        out_clause_sat        <= cs_nxt;
        out_unsat_count       <= cnt_nxt;
        out_first_unsat_idx   <= first_nxt;
        out_first_unsat_valid <= fv_nxt;
      end
    end
  end

endmodule
